// File: rtl/histogram_classifier.sv
// Scans a 4096-pixel frame of 6-bit codes into a 64-bin saturating histogram,
// then classifies the frame from bins 0, 34, 38 and 39.
module histogram_classifier #(
  parameter logic [11:0] TH0  = 12'd3000,
  parameter logic [11:0] TH34 = 12'd200,
  parameter logic [11:0] TH38 = 12'd150,
  parameter logic [11:0] TH39 = 12'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [11:0] pix_addr,
  input  logic [5:0]  pix_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  class_out,
  output logic [11:0] bin_0,
  output logic [11:0] bin_34,
  output logic [11:0] bin_38,
  output logic [11:0] bin_39
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, CLASSIFY, DONE} state_t;

  state_t             state, state_nxt;
  logic [63:0][11:0]  hist;
  logic               addr_vld;   // stage 1: address presented this cycle
  logic               data_vld;   // stage 2: pix_data valid this cycle
  logic               accept;
  logic [1:0]         class_nxt;

  assign accept   = start && (state == IDLE || state == DONE);
  assign addr_vld = (state == SCAN);
  assign busy     = (state == SCAN) || (state == DRAIN) || (state == CLASSIFY);
  assign done     = (state == DONE);
  assign bin_0    = hist[0];
  assign bin_34   = hist[34];
  assign bin_38   = hist[38];
  assign bin_39   = hist[39];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = SCAN;
      SCAN:       if (pix_addr == 12'hFFF) state_nxt = DRAIN;
      DRAIN:      state_nxt = CLASSIFY;
      CLASSIFY:   state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Priority decision tree; infected-like bins dominate the clean-bin test.
  always_comb begin
    if (hist[39] > TH39)      class_nxt = 2'b01;
    else if (hist[38] > TH38) class_nxt = 2'b01;
    else if (hist[34] > TH34) class_nxt = 2'b10;
    else if (hist[0] >= TH0)  class_nxt = 2'b00;
    else                      class_nxt = 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pix_addr  <= '0;
      data_vld  <= 1'b0;
      hist      <= '0;
      class_out <= 2'b00;
    end else begin
      state    <= state_nxt;
      data_vld <= addr_vld;
      if (accept) begin
        hist     <= '0;
        pix_addr <= '0;
      end else begin
        if (state == SCAN && pix_addr != 12'hFFF)
          pix_addr <= pix_addr + 12'd1;
        // data_vld is never high in IDLE/DONE, so it cannot collide with the clear
        if (data_vld && hist[pix_data] != 12'hFFF)
          hist[pix_data] <= hist[pix_data] + 12'd1;
      end
      if (state == CLASSIFY)
        class_out <= class_nxt;
    end
  end

endmodule

// File: tb/tb_histogram_classifier.sv
// Directed + randomized frames against a counting reference model.
module tb_histogram_classifier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] pix_addr;
  logic [5:0]  pix_data;
  logic        busy, done;
  logic [1:0]  class_out;
  logic [11:0] bin_0, bin_34, bin_38, bin_39;

  logic [5:0]  mem [4096];
  int          n_pass = 0;
  int          n_total = 0;
  logic [1:0]  last_class;
  int          e0, e34, e38, e39;
  logic [1:0]  ecls;

  always #5 clk = ~clk;
  always @(posedge clk) pix_data <= mem[pix_addr];

  histogram_classifier dut (
    .clk(clk), .rst(rst), .start(start), .pix_addr(pix_addr), .pix_data(pix_data),
    .busy(busy), .done(done), .class_out(class_out),
    .bin_0(bin_0), .bin_34(bin_34), .bin_38(bin_38), .bin_39(bin_39)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: plain per-value counts, clipped at 4095, then the rule table.
  task automatic model();
    int cnt [64];
    foreach (cnt[v]) cnt[v] = 0;
    for (int i = 0; i < 4096; i++) cnt[mem[i]]++;
    e0  = (cnt[0]  > 4095) ? 4095 : cnt[0];
    e34 = (cnt[34] > 4095) ? 4095 : cnt[34];
    e38 = (cnt[38] > 4095) ? 4095 : cnt[38];
    e39 = (cnt[39] > 4095) ? 4095 : cnt[39];
    if (e39 > 100)       ecls = 2'b01;
    else if (e38 > 150)  ecls = 2'b01;
    else if (e34 > 200)  ecls = 2'b10;
    else if (e0 >= 3000) ecls = 2'b00;
    else                 ecls = 2'b10;
  endtask

  task automatic fill_const(input logic [5:0] v, input int n);
    for (int i = 0; i < 4096; i++) mem[i] = (i < n) ? v : 6'd0;
  endtask

  task automatic fill_random();
    int t39, t38, t34, tz, r;
    t39 = $urandom_range(0, 40);
    t38 = $urandom_range(0, 50);
    t34 = $urandom_range(0, 70);
    tz  = $urandom_range(600, 950);
    for (int i = 0; i < 4096; i++) begin
      r = $urandom_range(0, 999);
      if (r < t39)                      mem[i] = 6'd39;
      else if (r < t39 + t38)           mem[i] = 6'd38;
      else if (r < t39 + t38 + t34)     mem[i] = 6'd34;
      else if (r < t39 + t38 + t34 + tz) mem[i] = 6'd0;
      else                              mem[i] = 6'($urandom_range(1, 63));
    end
  endtask

  // One full run; optional start pulse at edge pulse_at (relative to E0).
  task automatic run(input string tag, input int pulse_at);
    model();
    @(negedge clk) start = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk) start = 1'b0;
    check({tag, " busy@E0"}, busy, 1);
    check({tag, " done@E0"}, done, 0);
    check({tag, " bin0 cleared"}, bin_0, 0);
    check({tag, " class held"}, class_out, last_class);
    if (pulse_at > 0) begin
      repeat (pulse_at - 1) @(posedge clk);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      check({tag, " busy after pulse"}, busy, 1);
      repeat (4097 - pulse_at) @(posedge clk);
    end else begin
      repeat (4097) @(posedge clk);       // up to E4097
    end
    @(negedge clk);
    check({tag, " done@E4097"}, done, 0);
    check({tag, " class before CLASSIFY"}, class_out, last_class);
    @(posedge clk);                       // E4098
    @(negedge clk);
    check({tag, " done@E4098"}, done, 1);
    check({tag, " busy@E4098"}, busy, 0);
    check({tag, " class"}, class_out, ecls);
    check({tag, " bin_0"}, bin_0, e0);
    check({tag, " bin_34"}, bin_34, e34);
    check({tag, " bin_38"}, bin_38, e38);
    check({tag, " bin_39"}, bin_39, e39);
    last_class = ecls;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, " done held"}, done, 1);
    check({tag, " class held in DONE"}, class_out, ecls);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; last_class = 2'b00;
    fill_const(6'd0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset class", class_out, 0);
    check("reset addr", pix_addr, 0);
    check("reset bin_0", bin_0, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle without start", busy, 0);

    fill_const(6'd0, 0);   run("all zero", 0);
    for (int i = 0; i < 4096; i++) mem[i] = i[5:0];
    run("addr pattern", 0);
    fill_const(6'd39, 200); run("39x200", 0);
    fill_const(6'd38, 200); run("38x200", 0);
    fill_const(6'd34, 250); run("34x250", 0);
    fill_const(6'd34, 200); run("34x200 boundary", 0);

    // Mid-scan reset, then a clean rerun of the all-zero frame
    fill_const(6'd0, 0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (999) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst class", class_out, 0);
    check("midrst bin_0", bin_0, 0);
    check("midrst addr", pix_addr, 0);
    @(negedge clk) rst = 1'b0;
    last_class = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst idle", busy, 0);
    run("after reset", 0);

    fill_random(); run("rand pulse", 500);
    fill_random(); run("rand a", 0);
    fill_random(); run("rand b", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/histogram_classifier.md
HISTOGRAM_CLASSIFIER -- requirements
Module: histogram_classifier

Interface
REQ-001 Reset rst, asynchronous, active-high; clock clk.
REQ-002 Parameter TH0, default 12'd3000, minimum bin_0 count for an uninfected class.
REQ-003 Parameter TH34, default 12'd200, bin_34 threshold.
REQ-004 Parameter TH38, default 12'd150, bin_38 threshold.
REQ-005 Parameter TH39, default 12'd100, bin_39 threshold.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  async active-high reset.
REQ-008 start  input  1  level-sampled run request; honoured only in IDLE or DONE.
REQ-009 pix_addr  output  12  pixel memory read address.
REQ-010 pix_data  input  6  quantized pixel; external synchronous read, valid the cycle after pix_addr is presented.
REQ-011 busy  output  1  high in SCAN, DRAIN and CLASSIFY.
REQ-012 done  output  1  high in DONE.
REQ-013 class_out  output  2  registered classification.
REQ-014 bin_0, bin_34, bin_38, bin_39  output  12 each  current histogram counts.

Function
REQ-015 States: IDLE, SCAN, DRAIN, CLASSIFY, DONE; unsigned compares throughout.
REQ-016 Histogram: 64 bins x 12 bits in a register array, indexed by pix_data.
REQ-017 Edge E0 samples start=1 in IDLE/DONE: all 64 bins cleared, pix_addr <= 0, done <= 0, state <= SCAN.
REQ-018 SCAN: pix_addr increments by 1 per edge; on the edge where pix_addr==4095, state <= DRAIN and pix_addr holds 4095.
REQ-019 Sample pipeline: 2-stage valid shift register fed by (state==SCAN); the bin indexed by pix_data increments on every edge where stage-2 valid is 1, so address k updates at edge E(k+2).
REQ-020 The final update (address 4095) occurs at E4097, the DRAIN-exit edge; DRAIN then goes to CLASSIFY.
REQ-021 Bin increment saturates at 4095 (4096 equal pixels -> 4095).
REQ-022 CLASSIFY (one cycle) registers class_out at E4098 and goes to DONE; done=1 from E4098, i.e. latency 4098 edges after E0.
REQ-023 Decision tree, priority order: bin_39 > TH39 -> 2'b01; else bin_38 > TH38 -> 2'b01; else bin_34 > TH34 -> 2'b10; else bin_0 >= TH0 -> 2'b00; else 2'b10.
REQ-024 DONE holds done=1, class_out and all bins until the next accepted start.
REQ-025 start in SCAN, DRAIN or CLASSIFY is ignored and does not restart or extend the run.
REQ-026 class_out changes only at the CLASSIFY edge or on reset.
REQ-027 bin outputs are live during SCAN/DRAIN and final from DONE.

Reset
REQ-028 rst=1 at any time, including mid-scan: state=IDLE, pix_addr=0, valid pipeline=0, all bins=0, class_out=2'b00, done=0, busy=0.
REQ-029 After rst releases, the block waits in IDLE for start; a fresh run after a mid-scan reset yields the same result as an uninterrupted run.

Verification
REQ-030 All pixels 0 -> bin_0=4095 (saturated), bin_34, bin_38 and bin_39 all 0, class_out=2'b00, done at E4098.
REQ-031 pix_data = address[5:0] -> bin_0, bin_34, bin_38 and bin_39 all 64, class_out=2'b10 (no threshold met, bin_0 < TH0).
REQ-032 Addresses 0..199 = 39, rest 0 -> bin_39=200, bin_0=3896, class_out=2'b01; repeat with value 38 (200 pixels) -> 2'b01.
REQ-033 Addresses 0..249 = 34, rest 0 -> bin_34=250, bin_0=3846, class_out=2'b10; boundary run with 200 pixels of 34 and 3896 of 0 -> 2'b00.
REQ-034 rst asserted at E1000 during SCAN -> immediately busy=0, done=0, bins 0, class_out=0; new start reproduces the REQ-030 result.
REQ-035 start pulsed at E500 mid-run -> ignored, done still at E4098; start in DONE -> done drops next edge and a new run completes 4098 edges later.
